// File: rtl/led_pwm_driver.sv
`default_nettype none
// ============================================================================
// Module      : led_pwm_driver
// Description : LED output stage with global PWM brightness and per-LED blink,
//               inputs shadowed at PWM period boundaries for glitch-free updates.
// Revision    : 1.0 - initial release
// ============================================================================
module led_pwm_driver #(
  parameter int DATA_W        = 10,
  parameter int PRESCALE      = 50,
  parameter int PWM_BITS      = 8,
  parameter int BLINK_PERIODS = 128
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                enable,
  input  logic [DATA_W-1:0]   pattern_in,
  input  logic [PWM_BITS-1:0] brightness,
  input  logic [DATA_W-1:0]   blink_mask,
  output logic [DATA_W-1:0]   led_out,
  output logic                period_start,
  output logic                blink_phase
);

  localparam int c_PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int c_BL_W = (BLINK_PERIODS > 1) ? $clog2(BLINK_PERIODS) : 1;
  localparam logic [c_PS_W-1:0]   c_PS_LAST = c_PS_W'(PRESCALE - 1);
  localparam logic [c_BL_W-1:0]   c_BL_LAST = c_BL_W'(BLINK_PERIODS - 1);
  localparam logic [PWM_BITS-1:0] c_PWM_MAX = '1;

  logic [c_PS_W-1:0]   r_prescaler;
  logic [PWM_BITS-1:0] r_pwm_cnt;
  logic [c_BL_W-1:0]   r_blink_cnt;
  logic [DATA_W-1:0]   r_pat_sh;
  logic [PWM_BITS-1:0] r_bright_sh;
  logic [DATA_W-1:0]   r_mask_sh;

  logic                w_tick;
  logic                w_boundary;
  logic                w_pwm_on;
  logic [DATA_W-1:0]   w_led_next;

  assign w_tick     = (r_prescaler == c_PS_LAST);
  assign w_boundary = w_tick && (r_pwm_cnt == c_PWM_MAX);
  // Full-scale brightness is special-cased so all-ones means never dark.
  assign w_pwm_on   = (r_bright_sh == c_PWM_MAX) ? 1'b1 : (r_pwm_cnt < r_bright_sh);
  assign w_led_next = r_pat_sh & {DATA_W{w_pwm_on}} & ~(r_mask_sh & {DATA_W{blink_phase}});

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_prescaler <= '0;
      r_pwm_cnt   <= '0;
    end else if (!enable) begin
      r_prescaler <= '0;
      r_pwm_cnt   <= '0;
    end else begin
      r_prescaler <= w_tick ? '0 : r_prescaler + c_PS_W'(1);
      if (w_tick) begin
        r_pwm_cnt <= r_pwm_cnt + PWM_BITS'(1);
      end
    end
  end

  // Shadows follow the inputs freely while disabled, otherwise only at boundaries.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pat_sh    <= '0;
      r_bright_sh <= '0;
      r_mask_sh   <= '0;
    end else if (!enable || w_boundary) begin
      r_pat_sh    <= pattern_in;
      r_bright_sh <= brightness;
      r_mask_sh   <= blink_mask;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_blink_cnt <= '0;
      blink_phase <= 1'b0;
    end else if (!enable) begin
      r_blink_cnt <= '0;
      blink_phase <= 1'b0;
    end else if (w_boundary) begin
      if (r_blink_cnt == c_BL_LAST) begin
        r_blink_cnt <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        r_blink_cnt <= r_blink_cnt + c_BL_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      led_out      <= '0;
      period_start <= 1'b0;
    end else begin
      led_out      <= enable ? w_led_next : '0;
      period_start <= enable & w_boundary;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_led_pwm_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_led_pwm_driver
// Description : Self-checking bench for led_pwm_driver with a period-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_led_pwm_driver;

  localparam int DW  = 10;
  localparam int PS  = 4;
  localparam int PB  = 4;
  localparam int BP  = 2;
  localparam int PER = PS * (1 << PB);

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          enable = 1'b0;
  logic [DW-1:0] pattern_in = '0;
  logic [PB-1:0] brightness = '0;
  logic [DW-1:0] blink_mask = '0;
  logic [DW-1:0] led_out;
  logic          period_start;
  logic          blink_phase;

  int tests_run = 0;
  int tests_failed = 0;

  led_pwm_driver #(
    .DATA_W(DW), .PRESCALE(PS), .PWM_BITS(PB), .BLINK_PERIODS(BP)
  ) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable),
    .pattern_in(pattern_in), .brightness(brightness), .blink_mask(blink_mask),
    .led_out(led_out), .period_start(period_start), .blink_phase(blink_phase)
  );

  always #5 clk = ~clk;

  // Reference model: time since enable decides position in period; boundary count decides blink phase.
  int            m_t = 0;
  int            m_nb = 0;
  logic [DW-1:0] m_pat = '0, m_mask = '0, m_led = '0;
  logic [PB-1:0] m_bright = '0;
  logic          m_ps = 1'b0, m_phase = 1'b0;

  always @(posedge clk or negedge reset_n) begin
    int   pos;
    logic on;
    if (!reset_n) begin
      m_t = 0; m_nb = 0; m_pat = '0; m_mask = '0; m_bright = '0;
      m_led = '0; m_ps = 1'b0; m_phase = 1'b0;
    end else if (!enable) begin
      m_t = 0; m_nb = 0; m_pat = pattern_in; m_mask = blink_mask; m_bright = brightness;
      m_led = '0; m_ps = 1'b0; m_phase = 1'b0;
    end else begin
      pos   = m_t % PER;
      on    = (int'(m_bright) == (1 << PB) - 1) || ((pos / PS) < int'(m_bright));
      m_led = on ? (m_pat & ~(m_phase ? m_mask : '0)) : '0;
      m_ps  = (pos == PER - 1);
      m_t++;
      if (pos == PER - 1) begin
        m_nb++;
        m_pat = pattern_in; m_mask = blink_mask; m_bright = brightness;
        m_phase = ((m_nb / BP) % 2) == 1;
      end
    end
  end

  task automatic wait_ps(input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (period_start === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; enable = 1'b0;
    repeat (3) @(negedge clk);
    tests_run++;
    if ({led_out, period_start, blink_phase} !== '0) begin
      tests_failed++;
      $display("FAIL reset_state: got led=%h ps=%b ph=%b, expected all 0", led_out, period_start, blink_phase);
    end
  endtask

  task automatic test_powerup();
    int ps_seen = 0;
    reset_n = 1'b1; enable = 1'b1;
    pattern_in = 10'h3FF; brightness = 4'hF; blink_mask = '0;
    for (int i = 1; i <= PER + 1; i++) begin
      @(negedge clk);
      tests_run++;
      if (led_out !== ((i <= PER) ? 10'h000 : 10'h3FF) || period_start !== (i == PER)) begin
        tests_failed++;
        $display("FAIL powerup cycle %0d: got led=%h ps=%b", i, led_out, period_start);
      end
    end
    for (int i = 0; i < 3 * PER; i++) begin
      @(negedge clk);
      if (period_start) ps_seen++;
      tests_run++;
      if ({led_out, period_start, blink_phase} !== {m_led, m_ps, m_phase}) begin
        tests_failed++;
        $display("FAIL powerup_model: got led=%h ps=%b ph=%b expected led=%h ps=%b ph=%b",
                 led_out, period_start, blink_phase, m_led, m_ps, m_phase);
      end
    end
    tests_run++;
    if (ps_seen != 3) begin
      tests_failed++;
      $display("FAIL powerup_ps_count: got %0d expected 3", ps_seen);
    end
  endtask

  task automatic test_duty();
    bit ok;
    int high = 0;
    pattern_in = 10'h001; brightness = 4'h4; blink_mask = '0;
    wait_ps(2 * PER, ok);
    tests_run++;
    if (!ok) begin tests_failed++; $display("FAIL duty_wait: got no period_start expected one"); end
    for (int j = 1; j <= PER; j++) begin
      @(negedge clk);
      if (led_out[0]) high++;
      tests_run++;
      if (led_out !== ((j <= 16) ? 10'h001 : 10'h000)) begin
        tests_failed++;
        $display("FAIL duty cycle %0d: got led=%h expected %h", j, led_out, (j <= 16) ? 10'h001 : 10'h000);
      end
    end
    tests_run++;
    if (high != 16) begin tests_failed++; $display("FAIL duty_count: got %0d expected 16", high); end
  endtask

  task automatic test_glitch_free();
    bit ok;
    pattern_in = 10'h0F0; brightness = 4'hF; blink_mask = '0;
    wait_ps(2 * PER, ok);
    wait_ps(2 * PER, ok);
    repeat (30) @(negedge clk);
    pattern_in = 10'h00F;
    brightness = 4'h0;
    repeat (3) @(negedge clk);
    brightness = 4'hF;
    ok = 1'b0;
    for (int i = 0; i < PER; i++) begin
      @(negedge clk);
      tests_run++;
      if (led_out !== 10'h0F0) begin
        tests_failed++;
        $display("FAIL glitch_hold: got led=%h expected 0f0", led_out);
      end
      if (period_start) begin ok = 1'b1; break; end
    end
    tests_run++;
    if (!ok) begin tests_failed++; $display("FAIL glitch_wait: got no period_start expected one"); end
    @(negedge clk);
    tests_run++;
    if (led_out !== 10'h00F) begin
      tests_failed++;
      $display("FAIL glitch_switch: got led=%h expected 00f", led_out);
    end
  endtask

  task automatic test_blink();
    bit   ok;
    logic prev_ph;
    int   toggles = 0;
    pattern_in = 10'h003; brightness = 4'hF; blink_mask = 10'h002;
    wait_ps(2 * PER, ok);
    prev_ph = blink_phase;
    for (int i = 0; i < 4 * PER; i++) begin
      @(negedge clk);
      tests_run++;
      if (led_out !== (prev_ph ? 10'h001 : 10'h003)) begin
        tests_failed++;
        $display("FAIL blink_led: got led=%h expected %h", led_out, prev_ph ? 10'h001 : 10'h003);
      end
      if (blink_phase !== prev_ph) begin
        toggles++;
        tests_run++;
        if (period_start !== 1'b1) begin
          tests_failed++;
          $display("FAIL blink_toggle_align: got ps=%b expected 1", period_start);
        end
      end
      tests_run++;
      if ({led_out, period_start, blink_phase} !== {m_led, m_ps, m_phase}) begin
        tests_failed++;
        $display("FAIL blink_model: got led=%h ps=%b ph=%b expected led=%h ps=%b ph=%b",
                 led_out, period_start, blink_phase, m_led, m_ps, m_phase);
      end
      prev_ph = blink_phase;
    end
    tests_run++;
    if (toggles != 2) begin tests_failed++; $display("FAIL blink_toggles: got %0d expected 2", toggles); end
  endtask

  task automatic test_edge_duty();
    bit ok;
    pattern_in = 10'h3FF; brightness = 4'h0; blink_mask = '0;
    wait_ps(2 * PER, ok);
    for (int i = 0; i < PER; i++) begin
      @(negedge clk);
      tests_run++;
      if (led_out !== 10'h000) begin
        tests_failed++;
        $display("FAIL duty_zero: got led=%h expected 000", led_out);
      end
    end
    brightness = 4'hF;
    wait_ps(2 * PER, ok);
    for (int i = 0; i < PER; i++) begin
      @(negedge clk);
      tests_run++;
      if (led_out !== 10'h3FF) begin
        tests_failed++;
        $display("FAIL duty_full: got led=%h expected 3ff", led_out);
      end
    end
  endtask

  task automatic test_enable_mid();
    bit ok;
    int n = 0;
    wait_ps(2 * PER, ok);
    repeat (29) @(negedge clk);
    enable = 1'b0;
    pattern_in = 10'h0AA; brightness = 4'hF; blink_mask = '0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      tests_run++;
      if ({led_out, period_start, blink_phase} !== '0) begin
        tests_failed++;
        $display("FAIL disabled: got led=%h ps=%b ph=%b expected all 0", led_out, period_start, blink_phase);
      end
    end
    enable = 1'b1;
    for (int i = 1; i <= 3 * PER; i++) begin
      @(negedge clk);
      tests_run++;
      if ({led_out, period_start, blink_phase} !== {m_led, m_ps, m_phase}) begin
        tests_failed++;
        $display("FAIL reenable_model: got led=%h ps=%b expected led=%h ps=%b", led_out, period_start, m_led, m_ps);
      end
      if (period_start) begin n = i; break; end
    end
    tests_run++;
    if (n != PER) begin tests_failed++; $display("FAIL reenable_latency: got %0d expected %0d", n, PER); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int n = 0;
    wait_ps(2 * PER, ok);
    repeat (29) @(negedge clk);
    reset_n = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if ({led_out, period_start, blink_phase} !== '0) begin
        tests_failed++;
        $display("FAIL in_reset: got led=%h ps=%b ph=%b expected all 0", led_out, period_start, blink_phase);
      end
      @(negedge clk);
    end
    reset_n = 1'b1;
    for (int i = 1; i <= 3 * PER; i++) begin
      @(negedge clk);
      tests_run++;
      if (led_out !== 10'h000 && i <= PER) begin
        tests_failed++;
        $display("FAIL post_reset_led: got led=%h expected 000", led_out);
      end
      if (period_start) begin n = i; break; end
    end
    tests_run++;
    if (n != PER) begin tests_failed++; $display("FAIL post_reset_latency: got %0d expected %0d", n, PER); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      tests_run++;
      if ({led_out, period_start, blink_phase} !== {m_led, m_ps, m_phase}) begin
        tests_failed++;
        $display("FAIL random_model cycle %0d: got led=%h ps=%b ph=%b expected led=%h ps=%b ph=%b",
                 i, led_out, period_start, blink_phase, m_led, m_ps, m_phase);
      end
      if ($urandom_range(0, 15) == 0) pattern_in = DW'($urandom);
      if ($urandom_range(0, 15) == 0) brightness = PB'($urandom);
      if ($urandom_range(0, 15) == 0) blink_mask = DW'($urandom);
      if ($urandom_range(0, 299) == 0) enable = ~enable;
      if (!reset_n) reset_n = 1'b1;
      else if ($urandom_range(0, 999) == 0) reset_n = 1'b0;
    end
    reset_n = 1'b1;
    enable = 1'b1;
  endtask

  initial begin
    test_reset();
    test_powerup();
    test_duty();
    test_glitch_free();
    test_blink();
    test_edge_duty();
    test_enable_mid();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
